// File: rtl/calc_seq_bcd.sv
// Sequential add/sub/mul/div calculator with double-dabble BCD and 7-seg scan.
// Optional leading-zero blanking when CALC_LZB_EN is defined.
module calc_seq_bcd #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 5,
    parameter int SCAN_DIV = 2000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [3:0]            mode,
    output logic                  busy,
    output logic                  done,
    output logic [2*WIDTH-1:0]    result,
    output logic                  neg,
    output logic                  div_err,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an
);
    localparam int RW   = 2 * WIDTH;
    localparam int BW   = 4 * DIGITS;
    localparam int CNTW = $clog2(RW);
    localparam int SW   = $clog2(SCAN_DIV);
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, rem_q;
    logic [3:0]        mode_q;
    logic [RW-1:0]     acc_q, mcand_q, sh_q, result_q;
    logic [BW-1:0]     dig_q, bcd_q;
    logic [CNTW-1:0]   cnt_q;
    logic              neg_p_q, err_p_q, neg_q, err_q;

    logic [RW-1:0]     acc_n, mc_n;
    logic [WIDTH-1:0]  rem_n, quo_n, mr_n;
    logic [WIDTH:0]    r, diff;
    logic              neg_n, err_n, multi, calc_last, conv_last;
    logic [BW-1:0]     adj, dig_n;

    always_comb begin
        acc_n = '0;
        mc_n  = mcand_q;
        mr_n  = b_q;
        rem_n = rem_q;
        quo_n = a_q;
        neg_n = 1'b0;
        err_n = 1'b0;
        multi = 1'b0;
        r     = {rem_q, a_q[WIDTH-1]};
        diff  = r - {1'b0, b_q};
        case (mode_q)
            4'b0001: acc_n = RW'(a_q) + RW'(b_q);
            4'b0010: begin
                if (b_q > a_q) begin
                    acc_n = RW'(b_q - a_q);
                    neg_n = 1'b1;
                end else begin
                    acc_n = RW'(a_q - b_q);
                end
            end
            4'b0100: begin
                multi = 1'b1;
                acc_n = b_q[0] ? acc_q + mcand_q : acc_q;
                mc_n  = mcand_q << 1;
                mr_n  = b_q >> 1;
            end
            4'b1000: begin
                if (b_q == '0) begin
                    err_n = 1'b1;
                end else begin
                    multi = 1'b1;
                    // restoring step: keep the trial remainder only if non-negative
                    if (r >= {1'b0, b_q}) begin
                        rem_n = diff[WIDTH-1:0];
                        quo_n = {a_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_n = r[WIDTH-1:0];
                        quo_n = {a_q[WIDTH-2:0], 1'b0};
                    end
                    acc_n = RW'(quo_n);
                end
            end
            default: acc_n = '0;
        endcase
        calc_last = !multi || (cnt_q == CNTW'(WIDTH - 1));
        conv_last = (cnt_q == CNTW'(RW - 1));
    end

    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = (dig_q[4*i +: 4] >= 4'd5) ?
                            dig_q[4*i +: 4] + 4'd3 : dig_q[4*i +: 4];
        end
        dig_n = {adj[BW-2:0], sh_q[RW-1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (calc_last) state_d = CONV;
            CONV:    if (conv_last) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CALC) || (state_q == CONV);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            mode_q   <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            sh_q     <= '0;
            dig_q    <= '0;
            cnt_q    <= '0;
            neg_p_q  <= 1'b0;
            err_p_q  <= 1'b0;
            result_q <= '0;
            bcd_q    <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    a_q     <= a;
                    b_q     <= b;
                    mode_q  <= mode;
                    mcand_q <= RW'(a);
                    acc_q   <= '0;
                    rem_q   <= '0;
                    cnt_q   <= '0;
                end
                CALC: begin
                    a_q     <= quo_n;
                    b_q     <= mr_n;
                    mcand_q <= mc_n;
                    rem_q   <= rem_n;
                    acc_q   <= acc_n;
                    neg_p_q <= neg_n;
                    err_p_q <= err_n;
                    if (calc_last) begin
                        cnt_q <= '0;
                        sh_q  <= acc_n;
                        dig_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                CONV: begin
                    sh_q  <= sh_q << 1;
                    dig_q <= dig_n;
                    cnt_q <= cnt_q + CNTW'(1);
                    if (conv_last) begin
                        result_q <= acc_q;
                        bcd_q    <= dig_n;
                        neg_q    <= neg_p_q;
                        err_q    <= err_p_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result  = result_q;
    assign bcd     = bcd_q;
    assign neg     = neg_q;
    assign div_err = err_q;

    logic [SW-1:0]     scnt_q;
    logic [IW-1:0]     idx_q, shown_q;
    logic [DIGITS-1:0] an_q;
    logic              on_q;
    logic              wrap;

    assign wrap = (scnt_q == SW'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scnt_q  <= '0;
            idx_q   <= '0;
            shown_q <= '0;
            an_q    <= '1;
            on_q    <= 1'b0;
        end else if (wrap) begin
            scnt_q  <= '0;
            an_q    <= ~(DIGITS'(1) << idx_q);
            shown_q <= idx_q;
            on_q    <= 1'b1;
            idx_q   <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            scnt_q  <= scnt_q + SW'(1);
        end
    end

    assign an = an_q;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'b11111100;
            4'd1:    seg7 = 8'b01100000;
            4'd2:    seg7 = 8'b11011010;
            4'd3:    seg7 = 8'b11110010;
            4'd4:    seg7 = 8'b01100110;
            4'd5:    seg7 = 8'b10110110;
            4'd6:    seg7 = 8'b10111110;
            4'd7:    seg7 = 8'b11100000;
            4'd8:    seg7 = 8'b11111110;
            4'd9:    seg7 = 8'b11110110;
            default: seg7 = 8'b00000000;
        endcase
    endfunction

    logic [3:0] cur_dig;
    logic       blank;

    assign cur_dig = bcd_q[{shown_q, 2'b00} +: 4];

`ifdef CALC_LZB_EN
    logic [IW-1:0] msd;
    always_comb begin
        msd = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) msd = IW'(i);
        end
        blank = (shown_q > msd);
    end
`else
    assign blank = 1'b0;
`endif

    assign seg = (on_q && !blank) ? seg7(cur_dig) : 8'b00000000;

endmodule

// File: doc/calc_seq_bcd.md
# calc_seq_bcd

- Parametrised, sequential successor to the team's 4-bit binary calculator.
- Accepts WIDTH-bit unsigned operands and a one-hot mode on a start pulse.
- Computes add, subtract (magnitude plus sign), shift-add multiply or restoring divide over multiple cycles, then converts the result to BCD with a sequential double-dabble.
- Drives a DIGITS-digit multiplexed 7-segment display. It sits between the board switches/buttons and the display pins.

## Interface
- WIDTH, 8, operand width in bits (≥2).
- DIGITS, 5, number of BCD digits converted and scanned. Must satisfy 10^DIGITS > (2^WIDTH−1)^2.
- SCAN_DIV, 2000, clk cycles per displayed digit (≥2).

Ports (direction, width, meaning):
- clk  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request. Sampled only in IDLE.
- a  in  WIDTH  operand A, latched on accepted start.
- b  in  WIDTH  operand B, latched on accepted start.
- mode  in  4  one-hot: 0001 add, 0010 sub, 0100 mul, 1000 div.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; result outputs valid from this cycle.
- result  out  2*WIDTH  unsigned magnitude, zero-extended.
- neg  out  1  1 when the sub result is negative.
- div_err  out  1  1 on divide by zero.
- bcd  out  4*DIGITS  packed BCD of result; digit 0 in [3:0].
- seg  out  8  segments {a,b,c,d,e,f,g,dp}, active-high, dp always 0.
- an  out  DIGITS  digit enables, active-low, one-hot-low when scanning.

## Operation
- States: IDLE → CALC → CONV → DONE → IDLE.
- IDLE:
  - start=1 latches a, b, mode; busy=1 next cycle.
  - start while not IDLE is ignored; no queueing.
- CALC lasts C cycles:
  - add: result = a+b; C=1.
  - sub: if b>a, result = b−a and neg=1; else result = a−b and neg=0. C=1.
  - mul: shift-add, one multiplier bit per cycle; C=WIDTH.
  - div: restoring division, one quotient bit per cycle; result = floor(a/b) and remainder discarded; C=WIDTH.
  - div with b=0: result=0, div_err=1; C=1.
  - mode not one-hot: result=0, neg=0, div_err=0; C=1.
- CONV: double-dabble over the 2*WIDTH result bits, one bit per cycle (add-3 to every digit ≥5, then shift). Lasts 2*WIDTH cycles.
- DONE: done=1 for one cycle; busy=0 in the same cycle.
- result, neg, div_err and bcd update only in the DONE cycle and hold until the next DONE or reset. Intermediate values are never visible.
- Scan:
  - A free-running counter wraps at SCAN_DIV−1.
  - On each wrap the digit index advances 0,1,…,DIGITS−1,0.
  - an drives low only the bit for the current index.
  - seg shows the decoded bcd digit: 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110, 5=10110110, 6=10111110, 7=11100000, 8=11111110, 9=11110110. Any other value gives 00000000.
- Scan runs independently of the FSM. The display follows bcd, so it changes only at DONE.

## Timing
- Accepted start at edge k gives done high in the cycle after edge k+C+2*WIDTH.
- Latency L = C+2*WIDTH+1 cycles. For WIDTH=8: add/sub/div-by-zero/invalid L=18; mul/div L=25.
- Back-to-back: the next start is accepted in the cycle after done (IDLE).
- Reset values: busy 0, done 0, result 0, neg 0, div_err 0, bcd 0, seg 00000000, an all ones, scan counter 0, digit index 0, FSM IDLE.
- The first an/seg update occurs SCAN_DIV cycles after reset release.
- Reset mid-operation: immediate return to IDLE. No done pulse is produced and outputs show reset values.
- start and reset asserted together: reset wins.

## Configuration
- CALC_LZB_EN defined: leading-zero blanking. A digit above the most significant non-zero digit gets seg=00000000 while its an is still scanned. Digit 0 is always shown, so a result of 0 displays "0".
- CALC_LZB_EN undefined: every digit is decoded, including leading zeros.

## Test plan
- WIDTH=8, DIGITS=5; a=200, b=100, mode=0001, start pulse → done at k+18, result=300, bcd=0x00300, neg=0, busy high for 17 cycles.
- a=5, b=9, mode=0010 → result=4, neg=1, done at k+18. Then a=9, b=5 → result=4, neg=0.
- a=255, b=255, mode=0100 → done at k+25, result=65025, bcd=0x65025.
- a=200, b=7, mode=1000 → result=28, div_err=0, done at k+25. Then b=0 → result=0, div_err=1, done at k+18.
- Second start while busy → ignored, single done pulse. Reset asserted 10 cycles into a mul → no done, all outputs at reset values, next start accepted normally.
- SCAN_DIV=4, result=28:
  - an steps 11110, 11101, 11011, 10111, 01111 every 4 cycles.
  - With CALC_LZB_EN, digits 2–4 give seg=00000000; without it, they give 11111100.
